boot_copier: RTL and testbench
==============================

# boot_copier

Copy initiator for the word-addressed SRAM-style memory port used by the boot ROM. On a `start` pulse it reads `len` consecutive 32-bit words from a ROM-side port and writes them to a destination port that uses a req/gnt handshake. It sits between the FSBL ROM and system RAM and moves the boot image before the CPU is released. It also accumulates a 32-bit additive checksum of the copied words.

## Interface
- `DEPTH`, 4, entry count of the internal read-data FIFO; must be ≥3 for full throughput.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin copy; sampled only in IDLE.
- `src_base`  in  12  ROM byte address of first word; bits [1:0] ignored.
- `dst_base`  in  32  destination byte address of first word; bits [1:0] ignored.
- `len`  in  9  word count, 0..256; sampled with `start`.
- `busy`  out  1  high from the cycle after the accepted `start` until the cycle `done` pulses.
- `done`  out  1  one-cycle completion pulse.
- `checksum`  out  32  sum mod 2^32 of all words written.
- `rom_cen`  out  1  ROM read enable.
- `rom_addr`  out  12  ROM byte address, word-aligned.
- `rom_wdata`  out  32  tied to 0.
- `rom_wstrb`  out  4  tied to 0.
- `rom_rdata`  in  32  ROM read data, valid the cycle after `rom_cen`.
- `dst_req`  out  1  write request.
- `dst_gnt`  in  1  write accept; a transfer occurs on `dst_req & dst_gnt`.
- `dst_addr`  out  32  destination byte address.
- `dst_wdata`  out  32  write data.
- `dst_wstrb`  out  4  4'hF whenever `dst_req` is high, else 0.

## Operation
- States: IDLE, RUN, FINISH.
- **IDLE**
  - If `start` is high: latch `src_base`, `dst_base`, `len`; clear `checksum`, read counter and write counter.
  - With `len`≠0, go to RUN. With `len`=0, go to FINISH.
- **RUN, read side**
  - Issue a read (`rom_cen`=1, `rom_addr`=src_base+4·rd_cnt) when rd_cnt<len and fifo_count+inflight<DEPTH.
  - `inflight` is 1 in the cycle after an issue, else 0.
  - The `rom_rdata` of an inflight read is pushed into the FIFO at the end of that cycle.
  - `rom_addr` arithmetic is 12-bit and wraps mod 4096.
- **RUN, write side**
  - `dst_req` = FIFO non-empty. `dst_wdata` = FIFO head. `dst_addr` = dst_base+4·wr_cnt, 32-bit wrapping.
  - On a transfer: pop the FIFO, increment wr_cnt, and add `dst_wdata` to `checksum`.
  - While `dst_req` is high and `dst_gnt` is low, `dst_addr`, `dst_wdata` and `dst_wstrb` are held stable.
  - When wr_cnt reaches len after a transfer, go to FINISH.
- **FINISH**
  - `done`=1 for exactly one cycle, `busy`=0, then return to IDLE.
  - `checksum` holds its value until the next accepted `start`.
- `start` outside IDLE is ignored.
- Word order at the destination equals ROM read order. No word is dropped or duplicated under any `dst_gnt` pattern.
- FIFO overflow is impossible by the issue rule. The bench asserts that no push occurs while the FIFO is full.
- **Reset**
  - All state is cleared and the FIFO is flushed.
  - All outputs are 0: `busy`, `done`, `checksum`, `rom_cen`, `rom_addr`, `dst_req`, `dst_addr`, `dst_wdata`, `dst_wstrb`.
- **Reset mid-copy**: abort the copy with no `done` pulse. The next `start` operates normally.
- **`start` and `reset` in the same cycle**: reset wins.

## Timing
Cycle 0 is the edge at which `start` is sampled in IDLE.
- `busy` is high from cycle 1.
- The first `rom_cen` is in cycle 1, and its data is pushed at the end of cycle 2.
- The first `dst_req` is in cycle 3.
- With `dst_gnt` constantly 1:
  - one ROM read per cycle in cycles 1..len;
  - one write per cycle in cycles 3..len+2;
  - `done` in cycle len+3, with `busy` low in that cycle.
- With `len`=0: `done` in cycle 1, no `rom_cen`, no `dst_req`, `checksum`=0.
- All outputs are registered. The only combinational output is `dst_wstrb`, derived from the registered `dst_req`.

## Test plan
- **Basic copy**: `len`=4, `src_base`=0x000, `dst_base`=0x8000_0000, `dst_gnt`=1, ROM word k = 0x11111111·(k+1).
  - Writes at 0x80000000/04/08/0C carry 0x11111111..0x44444444 in cycles 3–6.
  - `done` in cycle 7; `checksum`=0xAAAAAAAA.
- **Zero length**: `len`=0 → `done` in cycle 1, no `rom_cen`/`dst_req`, `checksum`=0.
- **Backpressure**: `len`=8, `dst_gnt`=0 in cycles 3–12, then 1.
  - At most DEPTH reads are outstanding; `rom_cen` stalls.
  - `dst_addr`/`dst_wdata` are stable while stalled; all 8 words arrive in order.
  - `checksum` is correct.
- **Address wrap**:
  - `src_base`=0xFFC, `len`=2 → `rom_addr` 0xFFC then 0x000.
  - `dst_base`=0xFFFF_FFFC → `dst_addr` 0xFFFFFFFC then 0x00000000.
- **Reset mid-copy**: `len`=16, `reset` asserted after the 2nd write.
  - Next cycle all outputs are 0; no `done` pulse.
  - A subsequent `start` with `len`=2 completes with `done` in cycle 5.
- **Start while busy**: a second `start` with different `len` during RUN is ignored.
  - The copy completes with the original `len`.
  - Variant: `start` and `reset` together → stays IDLE.

Source files
------------

// File: rtl/boot_copier.sv
// boot_copier
//   Copies len consecutive 32-bit words from the boot ROM port to a
//   req/gnt destination port. It also keeps a 32-bit additive checksum of
//   every word written.
//   A small read-data FIFO sits between the two sides. A read is issued
//   only when the FIFO has room for it, counting the read already in
//   flight, so the FIFO can never overflow.
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   start                : begin a copy (accepted only in IDLE)
//   src_base, dst_base   : byte base addresses (bits [1:0] ignored)
//   len                  : word count 0..256, captured with start
//   busy, done, checksum : status, one-cycle completion pulse, word sum
//   rom_*                : ROM read port (data valid the cycle after rom_cen)
//   dst_*                : destination write port, transfer on req & gnt
module boot_copier #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] src_base,
  input  logic [31:0] dst_base,
  input  logic [8:0]  len,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum,
  output logic        rom_cen,
  output logic [11:0] rom_addr,
  output logic [31:0] rom_wdata,
  output logic [3:0]  rom_wstrb,
  input  logic [31:0] rom_rdata,
  output logic        dst_req,
  input  logic        dst_gnt,
  output logic [31:0] dst_addr,
  output logic [31:0] dst_wdata,
  output logic [3:0]  dst_wstrb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [11:0]    src_q, src_d;
  logic [31:0]    dst_base_q, dst_base_d;
  logic [8:0]     len_q, len_d;
  logic [8:0]     rd_cnt_q, rd_cnt_d;
  logic [8:0]     wr_cnt_q, wr_cnt_d;
  logic           inflight_q, inflight_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [31:0]    checksum_q, checksum_d;
  logic           rom_cen_q, rom_cen_d;
  logic [11:0]    rom_addr_q, rom_addr_d;
  logic           dst_req_q, dst_req_d;
  logic [31:0]    dst_addr_q, dst_addr_d;
  logic [31:0]    dst_wdata_q, dst_wdata_d;
  logic [31:0]    fifo_mem_q [DEPTH];

  logic           push_s;
  logic           pop_s;
  logic [CW-1:0]  remain_s;
  logic [CW:0]    occupancy_s;
  logic [8:0]     rd_cnt_n_s;
  logic [8:0]     wr_cnt_n_s;
  logic [31:0]    head_s;
  logic           unused_s;

  // Circular pointer increment; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Next-state and next-output computation for the whole copier.
  always_comb begin
    push_s      = inflight_q;
    pop_s       = dst_req_q & dst_gnt;
    remain_s    = fifo_cnt_q - CW'(pop_s);
    rd_cnt_n_s  = rd_cnt_q + 9'(rom_cen_q);
    wr_cnt_n_s  = wr_cnt_q + 9'(pop_s);

    state_d     = state_q;
    src_d       = src_q;
    dst_base_d  = dst_base_q;
    len_d       = len_q;
    rd_cnt_d    = rd_cnt_n_s;
    wr_cnt_d    = wr_cnt_n_s;
    inflight_d  = rom_cen_q;
    rd_ptr_d    = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d    = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    fifo_cnt_d  = remain_s + CW'(push_s);
    busy_d      = busy_q;
    done_d      = 1'b0;
    rom_cen_d   = 1'b0;
    rom_addr_d  = rom_addr_q;
    dst_addr_d  = dst_addr_q;

    if (pop_s) begin
      checksum_d = checksum_q + dst_wdata_q;
    end else begin
      checksum_d = checksum_q;
    end

    // The registered output stage mirrors the FIFO head of the next cycle.
    // When the FIFO drains to empty in the same cycle as a push, the new
    // head is the word arriving from the ROM this cycle.
    if (remain_s == {CW{1'b0}}) begin
      head_s = rom_rdata;
    end else begin
      head_s = fifo_mem_q[rd_ptr_d];
    end

    dst_req_d = (fifo_cnt_d != {CW{1'b0}});
    if (dst_req_d) begin
      dst_wdata_d = head_s;
    end else begin
      dst_wdata_d = 32'h0000_0000;
    end

    // Reads already issued but not yet in the FIFO must reserve a slot.
    occupancy_s = {1'b0, fifo_cnt_d} + (CW + 1)'(rom_cen_q);

    case (state_q)
      S_IDLE: begin
        busy_d    = 1'b0;
        dst_req_d = 1'b0;
        if (start) begin
          src_d      = {src_base[11:2], 2'b00};
          dst_base_d = {dst_base[31:2], 2'b00};
          len_d      = len;
          rd_cnt_d   = 9'd0;
          wr_cnt_d   = 9'd0;
          checksum_d = 32'h0000_0000;
          dst_addr_d = {dst_base[31:2], 2'b00};
          if (len != 9'd0) begin
            state_d    = S_RUN;
            busy_d     = 1'b1;
            rom_cen_d  = 1'b1;
            rom_addr_d = {src_base[11:2], 2'b00};
          end else begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        busy_d     = 1'b1;
        dst_addr_d = dst_base_q + {21'd0, wr_cnt_n_s, 2'b00};
        if ((rd_cnt_n_s < len_q) && (occupancy_s < (CW + 1)'(DEPTH))) begin
          rom_cen_d  = 1'b1;
          rom_addr_d = src_q + {1'b0, rd_cnt_n_s, 2'b00};
        end else begin
          rom_cen_d = 1'b0;
        end
        if (pop_s && (wr_cnt_n_s == len_q)) begin
          state_d   = S_FINISH;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          rom_cen_d = 1'b0;
          dst_req_d = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FINISH: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        dst_req_d = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        dst_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      src_q       <= 12'h000;
      dst_base_q  <= 32'h0000_0000;
      len_q       <= 9'd0;
      rd_cnt_q    <= 9'd0;
      wr_cnt_q    <= 9'd0;
      inflight_q  <= 1'b0;
      rd_ptr_q    <= {PW{1'b0}};
      wr_ptr_q    <= {PW{1'b0}};
      fifo_cnt_q  <= {CW{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= 32'h0000_0000;
      rom_cen_q   <= 1'b0;
      rom_addr_q  <= 12'h000;
      dst_req_q   <= 1'b0;
      dst_addr_q  <= 32'h0000_0000;
      dst_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_base_q  <= dst_base_d;
      len_q       <= len_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      inflight_q  <= inflight_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      checksum_q  <= checksum_d;
      rom_cen_q   <= rom_cen_d;
      rom_addr_q  <= rom_addr_d;
      dst_req_q   <= dst_req_d;
      dst_addr_q  <= dst_addr_d;
      dst_wdata_q <= dst_wdata_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers are flushed.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      fifo_mem_q[wr_ptr_q] <= rom_rdata;
    end
  end

  assign unused_s  = ^{src_base[1:0], dst_base[1:0]};

  assign busy      = busy_q;
  assign done      = done_q;
  assign checksum  = checksum_q;
  assign rom_cen   = rom_cen_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = 32'h0000_0000;
  assign rom_wstrb = 4'h0;
  assign dst_req   = dst_req_q;
  assign dst_addr  = dst_addr_q;
  assign dst_wdata = dst_wdata_q;
  assign dst_wstrb = dst_req_q ? 4'hF : 4'h0;

endmodule

// File: tb/tb_boot_copier.sv
// tb_boot_copier
//   Directed bench for boot_copier. The ROM model returns word k as
//   0x11111111*(k+1) one cycle after rom_cen. Each copy is stepped one cycle
//   at a time, and every ROM address, destination address and data word is
//   checked against values the bench computes itself.
module tb_boot_copier;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] src_base;
  logic [31:0] dst_base;
  logic [8:0]  len;
  logic        busy;
  logic        done;
  logic [31:0] checksum;
  logic        rom_cen;
  logic [11:0] rom_addr;
  logic [31:0] rom_wdata;
  logic [3:0]  rom_wstrb;
  logic [31:0] rom_rdata = 32'h0;
  logic        dst_req;
  logic        dst_gnt;
  logic [31:0] dst_addr;
  logic [31:0] dst_wdata;
  logic [3:0]  dst_wstrb;

  int total = 0;
  int bad   = 0;

  boot_copier #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_base(src_base), .dst_base(dst_base), .len(len),
    .busy(busy), .done(done), .checksum(checksum),
    .rom_cen(rom_cen), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .rom_wstrb(rom_wstrb), .rom_rdata(rom_rdata),
    .dst_req(dst_req), .dst_gnt(dst_gnt), .dst_addr(dst_addr),
    .dst_wdata(dst_wdata), .dst_wstrb(dst_wstrb)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [9:0] i);
    return 32'h11111111 * {22'd0, i} + 32'h11111111;
  endfunction

  // ROM model: registered read, data valid the cycle after rom_cen
  always @(posedge clk) begin
    if (rom_cen) rom_rdata <= rom_word(rom_addr[11:2]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"},      32'(busy),      32'd0);
    chk({tag, " done"},      32'(done),      32'd0);
    chk({tag, " checksum"},  checksum,       32'd0);
    chk({tag, " rom_cen"},   32'(rom_cen),   32'd0);
    chk({tag, " rom_addr"},  32'(rom_addr),  32'd0);
    chk({tag, " dst_req"},   32'(dst_req),   32'd0);
    chk({tag, " dst_addr"},  dst_addr,       32'd0);
    chk({tag, " dst_wdata"}, dst_wdata,      32'd0);
    chk({tag, " dst_wstrb"}, 32'(dst_wstrb), 32'd0);
  endtask

  // Runs one copy from the start pulse until one cycle after done.
  // Cycle numbers are counted from the edge that samples start (cycle 0).
  task automatic copy_run(input string tag, input logic [11:0] sb, input logic [31:0] db,
                          input int n, input int stall_lo, input int stall_hi,
                          input int restart_cyc, output int done_cyc, output int first_rd,
                          output int last_rd, output int first_req);
    int rd;
    int wr;
    logic [31:0] exp_sum;
    logic [11:0] exp_ra;
    logic [31:0] exp_da;
    logic [9:0]  widx;
    rd = 0; wr = 0; exp_sum = 32'h0;
    done_cyc = -1; first_rd = -1; last_rd = -1; first_req = -1;
    src_base = sb; dst_base = db; len = 9'(n); start = 1'b1; dst_gnt = 1'b1;
    tick();
    for (int c = 1; c <= 150 && done_cyc < 0; c++) begin
      if (c == restart_cyc) begin
        start = 1'b1; len = 9'd3;
      end else begin
        start = 1'b0; len = 9'(n);
      end
      dst_gnt = !(c >= stall_lo && c <= stall_hi);
      if (rom_cen) begin
        exp_ra = {sb[11:2], 2'b00} + 12'(4 * rd);
        chk({tag, " rom_addr"}, 32'(rom_addr), 32'(exp_ra));
        if (first_rd < 0) first_rd = c;
        last_rd = c;
        rd++;
      end
      chk({tag, " outstanding<=DEPTH"}, 32'((rd - wr) <= DEPTH), 32'd1);
      if (dst_req) begin
        exp_da = {db[31:2], 2'b00} + 32'(4 * wr);
        widx   = 10'(sb[11:2]) + 10'(wr);
        chk({tag, " dst_addr"},  dst_addr,       exp_da);
        chk({tag, " dst_wdata"}, dst_wdata,      rom_word(widx));
        chk({tag, " dst_wstrb"}, 32'(dst_wstrb), 32'hF);
        if (first_req < 0) first_req = c;
        if (dst_gnt) begin
          exp_sum = exp_sum + rom_word(widx);
          wr++;
        end
      end
      if (done) begin
        done_cyc = c;
        chk({tag, " busy at done"}, 32'(busy), 32'd0);
      end else begin
        chk({tag, " busy"}, 32'(busy), 32'd1);
      end
      tick();
    end
    start = 1'b0; dst_gnt = 1'b1; len = 9'(n);
    chk({tag, " done seen"},      32'(done_cyc > 0), 32'd1);
    chk({tag, " read count"},     32'(rd), 32'(n));
    chk({tag, " write count"},    32'(wr), 32'(n));
    chk({tag, " checksum model"}, checksum, exp_sum);
    chk({tag, " done one cycle"}, 32'(done), 32'd0);
    chk({tag, " busy after"},     32'(busy), 32'd0);
  endtask

  initial begin
    int dc;
    int fr;
    int lr;
    int fq;
    reset = 1'b1; start = 1'b0; src_base = 12'h0; dst_base = 32'h0;
    len = 9'd0; dst_gnt = 1'b1;
    tick(); tick(); tick();
    chk_zero("reset");
    chk("reset rom_wdata", rom_wdata, 32'd0);
    chk("reset rom_wstrb", 32'(rom_wstrb), 32'd0);
    reset = 1'b0;
    tick();

    // Basic copy: 4 words, constant grant
    copy_run("basic", 12'h000, 32'h8000_0000, 4, 1000, 0, 0, dc, fr, lr, fq);
    chk("basic done cycle", 32'(dc), 32'd7);
    chk("basic first rd",   32'(fr), 32'd1);
    chk("basic last rd",    32'(lr), 32'd4);
    chk("basic first req",  32'(fq), 32'd3);
    chk("basic checksum",   checksum, 32'hAAAA_AAAA);

    // Zero length
    copy_run("zero", 12'h010, 32'h0000_4000, 0, 1000, 0, 0, dc, fr, lr, fq);
    chk("zero done cycle", 32'(dc), 32'd1);
    chk("zero no req",     32'(fq), 32'hFFFF_FFFF);
    chk("zero checksum",   checksum, 32'd0);

    // Backpressure: grant low in cycles 3..12
    copy_run("bp", 12'h000, 32'h0000_2000, 8, 3, 12, 0, dc, fr, lr, fq);
    chk("bp done cycle", 32'(dc), 32'd21);
    chk("bp last rd",    32'(lr), 32'd17);
    chk("bp first req",  32'(fq), 32'd3);
    chk("bp checksum",   checksum, 32'h6666_6664);

    // Address wrap on both sides
    copy_run("wrap", 12'hFFC, 32'hFFFF_FFFC, 2, 1000, 0, 0, dc, fr, lr, fq);
    chk("wrap done cycle", 32'(dc), 32'd5);
    chk("wrap checksum",   checksum, 32'h5555_5511);

    // Reset after the second write of a 16-word copy
    src_base = 12'h000; dst_base = 32'h0000_1000; len = 9'd16; start = 1'b1; dst_gnt = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    chk_zero("midreset");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("midreset no done", 32'(done), 32'd0);
      chk("midreset idle",    32'(busy), 32'd0);
      tick();
    end
    copy_run("after reset", 12'h000, 32'h0000_1000, 2, 1000, 0, 0, dc, fr, lr, fq);
    chk("after reset done cycle", 32'(dc), 32'd5);
    chk("after reset checksum",   checksum, 32'h3333_3333);

    // A second start during RUN with a different length is ignored
    copy_run("restart", 12'h000, 32'h0000_3000, 5, 1000, 0, 2, dc, fr, lr, fq);
    chk("restart done cycle", 32'(dc), 32'd8);
    chk("restart checksum",   checksum, 32'hFFFF_FFFF);

    // start together with reset: stays idle
    reset = 1'b1; start = 1'b1; len = 9'd4;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("start+reset busy",     32'(busy),    32'd0);
    chk("start+reset rom_cen",  32'(rom_cen), 32'd0);
    chk("start+reset checksum", checksum,     32'd0);
    tick(); tick();
    chk("start+reset later busy", 32'(busy),    32'd0);
    chk("start+reset later req",  32'(dst_req), 32'd0);
    chk("start+reset later done", 32'(done),    32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
